noc_port_arbiter: RTL and testbench

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

---
 rtl/noc_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/noc_port_arbiter.sv | 122 ++++++++++++
 tb/tb_noc_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC port arbiter.
// Holds the arbiter FSM state encoding and the legal requester-count range.
package noc_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arbState_t;

   localparam int NUM_REQ_MIN = 2;
   localparam int NUM_REQ_MAX = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: the first set request at or after
// i_ptr (modulo NUM_REQ) wins, reported both one-hot and as an index.
import noc_arb_pkg::*;

module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_index
);

   // Walk from the farthest offset back to the pointer so the nearest request is written last.
   always_comb begin
      o_grant = '0;
      o_index = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_grant = '0;
            o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
            o_index = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-level round-robin arbiter feeding one NoC port through a single
// output register; a grant is held from sop to eop and protocol errors are sticky.
import noc_arb_pkg::*;

module noc_port_arbiter #(
   parameter  int PORT_WIDTH = 600,
   parameter  int NUM_REQ    = 4,
   localparam int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ*PORT_WIDTH-1:0] req_data_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   input  logic [NUM_REQ-1:0]            req_sop_in,
   input  logic [NUM_REQ-1:0]            req_eop_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   output logic [PORT_WIDTH-1:0]         o_data_out,
   output logic                          o_valid_out,
   input  logic                          o_ready_in,
   output logic [IDX_W-1:0]              o_grant_out,
   output logic                          o_err_out
);

   if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : gBadNumReq
      $error("noc_port_arbiter: NUM_REQ out of range");
   end

   arbState_t             r_state;
   logic [IDX_W-1:0]      r_rrPtr;
   logic [IDX_W-1:0]      r_grant;
   logic                  r_valid;
   logic                  r_err;
   logic                  r_firstFlit;
   logic [PORT_WIDTH-1:0] r_data;

   logic [NUM_REQ-1:0]    w_eligible;
   logic [NUM_REQ-1:0]    w_winOneHot;
   logic [IDX_W-1:0]      w_winIdx;
   logic [IDX_W-1:0]      w_nextPtr;
   logic                  w_anyEligible;
   logic                  w_badIdle;
   logic                  w_accept;
   logic                  w_xfer;
   logic [PORT_WIDTH-1:0] w_selData;

   assign w_eligible    = req_valid_in & req_sop_in;
   assign w_badIdle     = |(req_valid_in & ~req_sop_in);
   assign w_anyEligible = |w_winOneHot;
   assign w_accept      = !r_valid || o_ready_in;
   assign w_xfer        = (r_state == LOCKED) && req_valid_in[r_grant] && w_accept;
   assign w_selData     = req_data_in[int'(r_grant) * PORT_WIDTH +: PORT_WIDTH];
   assign w_nextPtr     = (w_winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : w_winIdx + 1'b1;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rrArbiter (
      .i_req   (w_eligible),
      .i_ptr   (r_rrPtr),
      .o_grant (w_winOneHot),
      .o_index (w_winIdx)
   );

   // Only the owner sees ready, and only while the output register can take a flit.
   always_comb begin
      req_ready_out = '0;
      if (r_state == LOCKED) begin
         req_ready_out[r_grant] = w_accept;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rrPtr     <= '0;
         r_grant     <= '0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
         r_firstFlit <= 1'b0;
         r_data      <= '0;
      end else begin
         if (w_xfer) begin
            r_data  <= w_selData;
            r_valid <= 1'b1;
         end else if (o_ready_in) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_badIdle) begin
                  r_err <= 1'b1;
               end
               if (w_anyEligible) begin
                  r_grant     <= w_winIdx;
                  r_rrPtr     <= w_nextPtr;
                  r_firstFlit <= 1'b1;
                  r_state     <= LOCKED;
               end
            end
            LOCKED: begin
               if (w_xfer) begin
                  r_firstFlit <= 1'b0;
                  // A repeated sop inside a packet is flagged but the flit still goes out.
                  if (req_sop_in[r_grant] && !r_firstFlit) begin
                     r_err <= 1'b1;
                  end
                  if (req_eop_in[r_grant]) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_data_out  = r_data;
   assign o_valid_out = r_valid;
   assign o_grant_out = r_grant;
   assign o_err_out   = r_err;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: packet drivers push expected flits
// into a scoreboard queue, an output monitor pops and compares them.
module tb_noc_port_arbiter;

   localparam int PW = 64;
   localparam int NR = 4;
   localparam int GW = $clog2(NR);

   logic             clk;
   logic             reset;
   logic [NR*PW-1:0] req_data_in;
   logic [NR-1:0]    req_valid_in;
   logic [NR-1:0]    req_sop_in;
   logic [NR-1:0]    req_eop_in;
   logic [NR-1:0]    req_ready_out;
   logic [PW-1:0]    o_data_out;
   logic             o_valid_out;
   logic             o_ready_in;
   logic [GW-1:0]    o_grant_out;
   logic             o_err_out;

   int               testCount = 0;
   int               failCount = 0;
   int               cyc = 0;
   int               multiReady = 0;
   bit               monEnable = 1'b1;
   logic [PW-1:0]    sbQ[$];
   int               outCycle[$];
   int               outReq[$];
   int               c0;

   noc_port_arbiter #(
      .PORT_WIDTH (PW),
      .NUM_REQ    (NR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_data_in   (req_data_in),
      .req_valid_in  (req_valid_in),
      .req_sop_in    (req_sop_in),
      .req_eop_in    (req_eop_in),
      .req_ready_out (req_ready_out),
      .o_data_out    (o_data_out),
      .o_valid_out   (o_valid_out),
      .o_ready_in    (o_ready_in),
      .o_grant_out   (o_grant_out),
      .o_err_out     (o_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] makeFlit(input int r, input int s);
      return {32'(r), 32'(s) ^ 32'h5A5A_0000};
   endfunction

   task automatic checkOutput(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Output monitor: every accepted output flit must match the scoreboard head.
   always @(negedge clk) begin
      if ($countones(req_ready_out) > 1) multiReady++;
      if (monEnable && o_valid_out && o_ready_in) begin
         outCycle.push_back(cyc);
         outReq.push_back(int'(o_data_out[PW-1:32]));
         if (sbQ.size() == 0) checkOutput("sbUnexpected", 1, 0);
         else checkOutput("sbData", o_data_out, sbQ.pop_front());
      end
   end

   // Drive one packet from requester r; entered and left #1 after a rising edge.
   task automatic applyStimulus(input int r, input int len, input int base, input bit midSop);
      for (int s = 0; s < len; s++) begin
         int waitCnt;
         bit done;
         waitCnt = 0;
         done = 1'b0;
         req_data_in[r*PW +: PW] = makeFlit(r, base + s);
         req_valid_in[r] = 1'b1;
         req_sop_in[r]   = (s == 0) || (midSop && s == 1);
         req_eop_in[r]   = (s == len - 1);
         while (!done) begin
            @(negedge clk);
            if (req_ready_out[r]) begin
               sbQ.push_back(makeFlit(r, base + s));
               done = 1'b1;
            end else begin
               waitCnt++;
               if (waitCnt > 60) begin
                  checkOutput("sendTimeout", 0, 1);
                  req_valid_in[r] = 1'b0;
                  req_sop_in[r]   = 1'b0;
                  req_eop_in[r]   = 1'b0;
                  return;
               end
            end
            @(posedge clk);
            #1;
         end
      end
      req_valid_in[r] = 1'b0;
      req_sop_in[r]   = 1'b0;
      req_eop_in[r]   = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic clearLogs();
      outCycle.delete();
      outReq.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int expOrder[5];
      reset        = 1'b1;
      req_data_in  = '0;
      req_valid_in = '0;
      req_sop_in   = '0;
      req_eop_in   = '0;
      o_ready_in   = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstValid", o_valid_out, 0);
      checkOutput("rstErr", o_err_out, 0);
      checkOutput("rstGrant", o_grant_out, 0);
      checkOutput("rstReady", req_ready_out, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // req0 3-flit packet: output on cycles 3,4,5 counting the first valid cycle as 1
      clearLogs();
      c0 = cyc;
      applyStimulus(0, 3, 0, 1'b0);
      drain();
      checkOutput("lat.count", outCycle.size(), 3);
      for (int i = 0; i < 3 && i < outCycle.size(); i++)
         checkOutput($sformatf("lat.cyc%0d", i), outCycle[i] - c0 + 1, 3 + i);
      checkOutput("lat.grant", o_grant_out, 0);

      // Pointer advanced to 1: req1 beats req0
      clearLogs();
      fork
         applyStimulus(0, 1, 100, 1'b0);
         applyStimulus(1, 1, 100, 1'b0);
      join
      drain();
      checkOutput("ptr.count", outReq.size(), 2);
      if (outReq.size() == 2) begin
         checkOutput("ptr.first", outReq[0], 1);
         checkOutput("ptr.second", outReq[1], 0);
      end

      // All four requesters, single-flit packets, from pointer 0
      pulseReset();
      clearLogs();
      fork
         begin
            applyStimulus(0, 1, 200, 1'b0);
            applyStimulus(0, 1, 201, 1'b0);
         end
         applyStimulus(1, 1, 200, 1'b0);
         applyStimulus(2, 1, 200, 1'b0);
         applyStimulus(3, 1, 200, 1'b0);
      join
      drain();
      expOrder = '{0, 1, 2, 3, 0};
      checkOutput("rr.count", outReq.size(), 5);
      for (int i = 0; i < 5 && i < outReq.size(); i++)
         checkOutput($sformatf("rr.order%0d", i), outReq[i], expOrder[i]);
      for (int i = 0; i < 4 && i + 1 < outCycle.size(); i++)
         checkOutput($sformatf("rr.gap%0d", i), outCycle[i+1] - outCycle[i], 2);

      // req2 mid-packet holds the grant against req1
      clearLogs();
      fork
         applyStimulus(2, 4, 300, 1'b0);
         begin
            repeat (2) @(posedge clk);
            #1;
            applyStimulus(1, 1, 310, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            repeat (3) begin
               @(negedge clk);
               checkOutput("hold.r1Ready", req_ready_out[1], 0);
            end
         end
      join
      drain();
      expOrder = '{2, 2, 2, 2, 1};
      checkOutput("hold.count", outReq.size(), 5);
      for (int i = 0; i < 5 && i < outReq.size(); i++)
         checkOutput($sformatf("hold.order%0d", i), outReq[i], expOrder[i]);

      // Output back-pressure for 5 cycles mid-packet
      clearLogs();
      fork
         applyStimulus(3, 4, 400, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1;
            o_ready_in = 1'b0;
            repeat (5) begin
               @(negedge clk);
               checkOutput("stall.valid", o_valid_out, 1);
               checkOutput("stall.data", o_data_out, (sbQ.size() > 0) ? sbQ[0] : '0);
               checkOutput("stall.ready", req_ready_out[3], 0);
            end
            @(posedge clk);
            #1;
            o_ready_in = 1'b1;
         end
      join
      drain();
      checkOutput("stall.count", outReq.size(), 4);
      checkOutput("stall.sbEmpty", sbQ.size(), 0);

      // Valid without sop in IDLE is ignored and flagged sticky
      checkOutput("err.before", o_err_out, 0);
      req_valid_in[3] = 1'b1;
      req_data_in[3*PW +: PW] = makeFlit(3, 450);
      @(negedge clk);
      checkOutput("err.r3Ready", req_ready_out[3], 0);
      @(posedge clk);
      #1;
      req_valid_in[3] = 1'b0;
      @(negedge clk);
      checkOutput("err.set", o_err_out, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("err.sticky", o_err_out, 1);

      // Repeated sop inside a packet: flagged, flits still forwarded
      pulseReset();
      checkOutput("err.cleared", o_err_out, 0);
      clearLogs();
      applyStimulus(1, 3, 500, 1'b1);
      drain();
      checkOutput("midSop.err", o_err_out, 1);
      checkOutput("midSop.count", outReq.size(), 3);

      // Reset asserted mid-packet abandons it and clears everything
      monEnable = 1'b0;
      req_data_in[2*PW +: PW] = makeFlit(2, 550);
      req_valid_in[2] = 1'b1;
      req_sop_in[2]   = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      req_sop_in[2] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midRst.grantBefore", o_grant_out, 2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midRst.valid", o_valid_out, 0);
      checkOutput("midRst.err", o_err_out, 0);
      checkOutput("midRst.grant", o_grant_out, 0);
      checkOutput("midRst.ready", req_ready_out, 0);
      req_valid_in = '0;
      req_sop_in   = '0;
      req_eop_in   = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sbQ.delete();
      monEnable = 1'b1;
      @(posedge clk);
      #1;

      // Normal traffic resumes after reset
      clearLogs();
      applyStimulus(2, 2, 600, 1'b0);
      drain();
      checkOutput("post.count", outReq.size(), 2);
      checkOutput("post.err", o_err_out, 0);
      checkOutput("final.sbEmpty", sbQ.size(), 0);
      checkOutput("final.multiReady", multiReady, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
